// File: rtl/tag_lookup_ctrl_pkg.sv
// rtl/tag_lookup_ctrl_pkg.sv - shared types and constants for the tag lookup sequencer
// Contents:
//   TLC_AWIDTH / TLC_DWIDTH  default index and RAM entry widths
//   VALID_BIT                position of the valid flag in a RAM entry
//   TAG_MSB                  top bit of the stored tag field
//   state_t                  sequencer states INIT / IDLE / CMP
package tag_lookup_ctrl_pkg;

    localparam int TLC_AWIDTH = 3;
    localparam int TLC_DWIDTH = 14;
    localparam int VALID_BIT  = TLC_DWIDTH - 1;
    localparam int TAG_MSB    = TLC_DWIDTH - 2;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        CMP  = 2'd2
    } state_t;

endpackage

// File: rtl/tag_lookup_ctrl_if.sv
// rtl/tag_lookup_ctrl_if.sv - lookup/response/fill bus between cache FSM and tag sequencer
// Signals:
//   req_valid/req_ready/req_index/req_tag     lookup request handshake
//   rsp_valid/rsp_hit/rsp_index               one-cycle lookup result
//   fill_valid/fill_ready/fill_index/fill_tag write-valid-tag handshake
// Modports: master = cache control FSM, slave = tag_lookup_ctrl
interface tag_lookup_ctrl_if #(
    parameter int AWIDTH = 3,
    parameter int DWIDTH = 14
);
    logic              req_valid;
    logic              req_ready;
    logic [AWIDTH-1:0] req_index;
    logic [DWIDTH-2:0] req_tag;
    logic              rsp_valid;
    logic              rsp_hit;
    logic [AWIDTH-1:0] rsp_index;
    logic              fill_valid;
    logic              fill_ready;
    logic [AWIDTH-1:0] fill_index;
    logic [DWIDTH-2:0] fill_tag;

    modport master (
        output req_valid, req_index, req_tag, fill_valid, fill_index, fill_tag,
        input  req_ready, fill_ready, rsp_valid, rsp_hit, rsp_index
    );

    modport slave (
        input  req_valid, req_index, req_tag, fill_valid, fill_index, fill_tag,
        output req_ready, fill_ready, rsp_valid, rsp_hit, rsp_index
    );
endinterface

// File: rtl/tag_lookup_ctrl.sv
// rtl/tag_lookup_ctrl.sv - clear/lookup/fill sequencer for one direct-mapped tag RAM bank
// Ports:
//   clock, reset       rising-edge clock, synchronous active-high reset
//   flush              re-runs the clear sweep when seen in IDLE
//   init_done          high in IDLE or CMP
//   bus (slave)        lookup request, lookup response and fill handshakes
//   ram_addr/din/we    drive the external tag RAM
//   ram_dout           RAM read data, one cycle after the address
module tag_lookup_ctrl
    import tag_lookup_ctrl_pkg::*;
#(
    parameter int AWIDTH = TLC_AWIDTH,
    parameter int DWIDTH = TLC_DWIDTH
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    output logic               init_done,
    tag_lookup_ctrl_if.slave   bus,
    output logic [AWIDTH-1:0]  ram_addr,
    output logic [DWIDTH-1:0]  ram_din,
    output logic               ram_we,
    input  logic [DWIDTH-1:0]  ram_dout
);

    state_t            state, state_nxt;
    logic [AWIDTH-1:0] cnt;
    logic [AWIDTH-1:0] addr_q;
    logic [AWIDTH-1:0] idx_q;
    logic [DWIDTH-2:0] tag_q;
    logic              rsp_valid_q;
    logic              rsp_hit_q;
    logic [AWIDTH-1:0] rsp_index_q;
    logic              lookup_fire;

    assign init_done     = (state == IDLE) || (state == CMP);
    assign bus.rsp_valid = rsp_valid_q && !reset;
    assign bus.rsp_hit   = rsp_hit_q;
    assign bus.rsp_index = rsp_index_q;
    assign lookup_fire   = bus.req_valid && bus.req_ready;

    always_comb begin
        state_nxt      = state;
        ram_we         = 1'b0;
        ram_addr       = addr_q;
        ram_din        = '0;
        bus.req_ready  = 1'b0;
        bus.fill_ready = 1'b0;
        case (state)
            INIT: begin
                ram_we   = 1'b1;
                ram_addr = cnt;
                if (cnt == {AWIDTH{1'b1}}) state_nxt = IDLE;
            end
            IDLE: begin
                if (flush) begin
                    state_nxt = INIT;
                end else begin
                    bus.fill_ready = 1'b1;
                    // Fills win over lookups so a pending write is never stalled.
                    bus.req_ready  = !bus.fill_valid;
                    if (bus.fill_valid) begin
                        ram_we   = 1'b1;
                        ram_addr = bus.fill_index;
                        ram_din  = {1'b1, bus.fill_tag};
                    end else if (bus.req_valid) begin
                        ram_addr  = bus.req_index;
                        state_nxt = CMP;
                    end
                end
            end
            CMP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = INIT;
            end
        endcase
        // Nothing reaches the RAM or the handshakes while reset is held.
        if (reset) begin
            ram_we         = 1'b0;
            bus.req_ready  = 1'b0;
            bus.fill_ready = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= INIT;
            cnt         <= '0;
            addr_q      <= '0;
            idx_q       <= '0;
            tag_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_index_q <= '0;
        end else begin
            state       <= state_nxt;
            addr_q      <= ram_addr;
            rsp_valid_q <= (state == CMP);
            if (state == INIT) begin
                cnt <= cnt + AWIDTH'(1);
            end else begin
                cnt <= '0;
            end
            if (state == IDLE && lookup_fire) begin
                idx_q <= bus.req_index;
                tag_q <= bus.req_tag;
            end
            if (state == CMP) begin
                rsp_hit_q   <= ram_dout[VALID_BIT] && (ram_dout[TAG_MSB:0] == tag_q);
                rsp_index_q <= idx_q;
            end
        end
    end

endmodule

// File: tb/tb_tag_lookup_ctrl.sv
// tb/tb_tag_lookup_ctrl.sv - self-checking bench for tag_lookup_ctrl
module tb_tag_lookup_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        init_done;
    logic [2:0]  ram_addr;
    logic [13:0] ram_din;
    logic        ram_we;
    logic [13:0] ram_dout;

    int errors = 0;
    int checks = 0;

    logic [13:0] mem   [8];
    logic [13:0] model [8];
    logic [3:0]  sb_q  [$];

    tag_lookup_ctrl_if #(.AWIDTH(3), .DWIDTH(14)) bus ();

    tag_lookup_ctrl #(.AWIDTH(3), .DWIDTH(14)) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .init_done (init_done),
        .bus       (bus),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_we    (ram_we),
        .ram_dout  (ram_dout)
    );

    always #5 clock = ~clock;

    // Tag RAM beside the block: synchronous read, one-cycle latency.
    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 14'h3FFF;
    end
    always @(posedge clock) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Response scoreboard: every rsp_valid pulse must match the oldest expectation.
    always @(negedge clock) begin
        if (bus.rsp_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_rsp: observed rsp_index=%0h with empty scoreboard expected=no pulse",
                       bus.rsp_index);
            end else begin
                logic [3:0] e;
                e = sb_q.pop_front();
                chk("rsp_hit", 32'(bus.rsp_hit), 32'(e[3]));
                chk("rsp_index", 32'(bus.rsp_index), 32'(e[2:0]));
            end
        end
    end

    // Entry point at posedge+1 with reset low and the DUT in INIT at cnt 0.
    task automatic sweep_check();
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("sweep_we", 32'(ram_we), 32'd1);
            chk("sweep_addr", 32'(ram_addr), 32'(i));
            chk("sweep_din", 32'(ram_din), 32'd0);
            chk("sweep_req_ready", 32'(bus.req_ready), 32'd0);
            chk("sweep_init_done", 32'(init_done), 32'd0);
            tick();
        end
        for (int i = 0; i < 8; i++) model[i] = 14'h0;
        chk("init_done_rise", 32'(init_done), 32'd1);
    endtask

    task automatic do_fill(input logic [2:0] idx, input logic [12:0] tag);
        bus.fill_valid = 1'b1;
        bus.fill_index = idx;
        bus.fill_tag   = tag;
        #1;
        chk("fill_ready", 32'(bus.fill_ready), 32'd1);
        chk("fill_we", 32'(ram_we), 32'd1);
        chk("fill_addr", 32'(ram_addr), 32'(idx));
        chk("fill_din", 32'(ram_din), 32'({1'b1, tag}));
        tick();
        bus.fill_valid = 1'b0;
        model[idx] = {1'b1, tag};
    endtask

    task automatic do_lookup(input logic [2:0] idx, input logic [12:0] tag);
        logic hit;
        hit = model[idx][13] && (model[idx][12:0] == tag);
        sb_q.push_back({hit, idx});
        bus.req_valid = 1'b1;
        bus.req_index = idx;
        bus.req_tag   = tag;
        #1;
        chk("req_ready", 32'(bus.req_ready), 32'd1);
        chk("lookup_we", 32'(ram_we), 32'd0);
        chk("lookup_addr", 32'(ram_addr), 32'(idx));
        tick();
        bus.req_valid = 1'b0;
        #1;
        chk("cmp_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("cmp_req_ready", 32'(bus.req_ready), 32'd0);
        chk("cmp_fill_ready", 32'(bus.fill_ready), 32'd0);
        tick();
        chk("rsp_valid_t2", 32'(bus.rsp_valid), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_index  = '0;
        bus.req_tag    = '0;
        bus.fill_valid = 1'b0;
        bus.fill_index = '0;
        bus.fill_tag   = '0;
        for (int i = 0; i < 8; i++) model[i] = 14'h3FFF;

        repeat (3) tick();
        chk("rst_we", 32'(ram_we), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_fill_ready", 32'(bus.fill_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_hit", 32'(bus.rsp_hit), 32'd0);
        chk("rst_rsp_index", 32'(bus.rsp_index), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        reset = 1'b0;
        sweep_check();
        #1;
        chk("idle_we", 32'(ram_we), 32'd0);
        chk("idle_fill_ready", 32'(bus.fill_ready), 32'd1);
        tick();

        // Miss on a freshly cleared entry, then fill and hit on the next cycle.
        do_lookup(3'd5, 13'h0ABC);
        do_fill(3'd5, 13'h0ABC);
        do_lookup(3'd5, 13'h0ABC);
        do_lookup(3'd5, 13'h0ABD);
        do_lookup(3'd0, 13'h0000);

        // Back-to-back fills, then boundary indices.
        do_fill(3'd1, 13'h1FFF);
        do_fill(3'd7, 13'h0001);
        do_lookup(3'd7, 13'h0001);
        do_lookup(3'd1, 13'h1FFF);
        do_lookup(3'd1, 13'h0FFF);

        // Fill and lookup together: fill wins, lookup goes the next cycle.
        bus.fill_valid = 1'b1;
        bus.fill_index = 3'd6;
        bus.fill_tag   = 13'h0555;
        bus.req_valid  = 1'b1;
        bus.req_index  = 3'd6;
        bus.req_tag    = 13'h0555;
        #1;
        chk("both_req_ready", 32'(bus.req_ready), 32'd0);
        chk("both_fill_ready", 32'(bus.fill_ready), 32'd1);
        chk("both_we", 32'(ram_we), 32'd1);
        chk("both_addr", 32'(ram_addr), 32'd6);
        tick();
        bus.fill_valid = 1'b0;
        model[6] = {1'b1, 13'h0555};
        do_lookup(3'd6, 13'h0555);

        // Fill then flush: sweep re-runs and the fill is gone.
        do_fill(3'd2, 13'h1234);
        flush         = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_index = 3'd2;
        bus.req_tag   = 13'h1234;
        #1;
        chk("flush_req_ready", 32'(bus.req_ready), 32'd0);
        chk("flush_fill_ready", 32'(bus.fill_ready), 32'd0);
        chk("flush_we", 32'(ram_we), 32'd0);
        tick();
        flush = 1'b0;
        sweep_check();
        do_lookup(3'd2, 13'h1234);

        // Reset during CMP drops the pending response.
        do_fill(3'd4, 13'h0777);
        bus.req_valid = 1'b1;
        bus.req_index = 3'd4;
        bus.req_tag   = 13'h0777;
        #1;
        chk("pre_rst_req_ready", 32'(bus.req_ready), 32'd1);
        tick();
        bus.req_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("cmp_rst_we", 32'(ram_we), 32'd0);
        chk("cmp_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        tick();
        chk("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("post_rst_init_done", 32'(init_done), 32'd0);
        reset = 1'b0;
        sweep_check();
        do_lookup(3'd4, 13'h0777);

        tick();
        tick();
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
